// File: rtl/wave_pkg.sv
// Shared types and helpers for the wave_detect waveform classifier:
// wave type codes, delta classes, lock FSM states and window judgement.
package wave_pkg;

  localparam logic [1:0] WT_SQUARE = 2'b00;
  localparam logic [1:0] WT_SAW    = 2'b01;
  localparam logic [1:0] WT_TRI    = 2'b10;
  localparam logic [1:0] WT_UNK    = 2'b11;

  typedef enum logic [2:0] {
    DC_ZERO = 3'd0,
    DC_UP1  = 3'd1,
    DC_DN1  = 3'd2,
    DC_JUP  = 3'd3,
    DC_JDN  = 3'd4
  } delta_cls_e;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  // Samples are unsigned 5-bit, so the step always fits a 6-bit signed value.
  function automatic delta_cls_e classify(input logic [4:0] cur, input logic [4:0] prv);
    logic signed [5:0] d;
    delta_cls_e        c;
    d = $signed({1'b0, cur}) - $signed({1'b0, prv});
    if (d == 6'sd0)       c = DC_ZERO;
    else if (d == 6'sd1)  c = DC_UP1;
    else if (d == -6'sd1) c = DC_DN1;
    else if (d > 6'sd1)   c = DC_JUP;
    else                  c = DC_JDN;
    return c;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic en);
    return (en && (c != 8'hFF)) ? c + 8'd1 : c;
  endfunction

  function automatic logic [1:0] judge(input logic [7:0] up1, input logic [7:0] dn1,
                                       input logic [7:0] jup, input logic [7:0] jdn);
    logic [1:0] v;
    if ((up1 != 8'd0) && (dn1 != 8'd0) && (jup == 8'd0) && (jdn == 8'd0))      v = WT_TRI;
    else if ((up1 != 8'd0) && (jdn != 8'd0) && (dn1 == 8'd0) && (jup == 8'd0)) v = WT_SAW;
    else if ((jup != 8'd0) && (jdn != 8'd0) && (up1 == 8'd0) && (dn1 == 8'd0)) v = WT_SQUARE;
    else                                                                       v = WT_UNK;
    return v;
  endfunction

endpackage

// File: rtl/wave_win_stats.sv
// Delta classifier and windowed class statistics. Emits the registered delta
// class every cycle and a one-cycle window-end strobe with the window verdict.
module wave_win_stats
  import wave_pkg::*;
#(
  parameter int WIN = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_wave,
  output logic       o_dvalid,
  output delta_cls_e o_cls,
  output logic       o_win_end,
  output logic [1:0] o_verdict
);

  logic       r_primed;
  logic [4:0] r_prev;
  logic [7:0] r_wcnt;
  logic [7:0] r_zero, r_up1, r_dn1, r_jup, r_jdn;
  logic       r_dvalid;
  delta_cls_e r_cls;
  logic       r_win_end;
  logic [1:0] r_verdict;

  delta_cls_e w_cls;
  logic [7:0] w_zero_n, w_up1_n, w_dn1_n, w_jup_n, w_jdn_n;
  logic       w_last;

  // The judged window includes the delta that closes it.
  always_comb begin
    w_cls    = classify(i_wave, r_prev);
    w_zero_n = sat_inc(r_zero, w_cls == DC_ZERO);
    w_up1_n  = sat_inc(r_up1,  w_cls == DC_UP1);
    w_dn1_n  = sat_inc(r_dn1,  w_cls == DC_DN1);
    w_jup_n  = sat_inc(r_jup,  w_cls == DC_JUP);
    w_jdn_n  = sat_inc(r_jdn,  w_cls == DC_JDN);
    w_last   = (r_wcnt == 8'(WIN - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_primed  <= 1'b0;
      r_prev    <= 5'd0;
      r_wcnt    <= 8'd0;
      r_zero    <= 8'd0;
      r_up1     <= 8'd0;
      r_dn1     <= 8'd0;
      r_jup     <= 8'd0;
      r_jdn     <= 8'd0;
      r_dvalid  <= 1'b0;
      r_cls     <= DC_ZERO;
      r_win_end <= 1'b0;
      r_verdict <= WT_UNK;
    end else begin
      r_dvalid  <= r_primed;
      r_win_end <= 1'b0;
      r_prev    <= i_wave;
      if (!r_primed) begin
        r_primed <= 1'b1;
      end else begin
        r_cls <= w_cls;
        if (w_last) begin
          r_wcnt    <= 8'd0;
          r_zero    <= 8'd0;
          r_up1     <= 8'd0;
          r_dn1     <= 8'd0;
          r_jup     <= 8'd0;
          r_jdn     <= 8'd0;
          r_win_end <= 1'b1;
          r_verdict <= judge(w_up1_n, w_dn1_n, w_jup_n, w_jdn_n);
        end else begin
          r_wcnt <= r_wcnt + 8'd1;
          r_zero <= w_zero_n;
          r_up1  <= w_up1_n;
          r_dn1  <= w_dn1_n;
          r_jup  <= w_jup_n;
          r_jdn  <= w_jdn_n;
        end
      end
    end
  end

  assign o_dvalid  = r_dvalid;
  assign o_cls     = r_cls;
  assign o_win_end = r_win_end;
  assign o_verdict = r_verdict;

endmodule

// File: rtl/wave_detect.sv
// Waveform classifier top: lock FSM over window verdicts and period
// measurement from falling jumps and valleys of the sample stream.
module wave_detect
  import wave_pkg::*;
#(
  parameter int WIN     = 64,
  parameter int CONFIRM = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  wave,
  output logic [1:0]  wave_type,
  output logic        locked,
  output logic        type_chg,
  output logic [7:0]  period,
  output logic        period_valid,
  output lock_state_e o_dbg_state
);

  logic       w_dvalid;
  delta_cls_e w_cls;
  logic       w_win_end;
  logic [1:0] w_verdict;

  wave_win_stats #(.WIN(WIN)) u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wave    (wave),
    .o_dvalid  (w_dvalid),
    .o_cls     (w_cls),
    .o_win_end (w_win_end),
    .o_verdict (w_verdict)
  );

  lock_state_e r_state, w_state_n;
  logic [1:0]  r_cand, w_cand_n;
  logic [2:0]  r_agree, w_agree_n;
  logic [1:0]  r_wave_type, w_type_n;
  logic        r_type_chg, w_chg_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_UNLOCKED;
      r_cand      <= WT_UNK;
      r_agree     <= 3'd0;
      r_wave_type <= WT_UNK;
      r_type_chg  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cand      <= w_cand_n;
      r_agree     <= w_agree_n;
      r_wave_type <= w_type_n;
      r_type_chg  <= w_chg_n;
    end
  end

  // Leaving LOCKED reuses the unlocked candidate rules on the same verdict.
  always_comb begin
    w_state_n = r_state;
    w_cand_n  = r_cand;
    w_agree_n = r_agree;
    w_type_n  = r_wave_type;
    w_chg_n   = 1'b0;
    if (w_win_end && !((r_state == ST_LOCKED) && (w_verdict == r_wave_type))) begin
      w_state_n = ST_UNLOCKED;
      if (w_verdict == WT_UNK) begin
        w_agree_n = 3'd0;
      end else begin
        if (w_verdict == r_cand) begin
          w_agree_n = r_agree + 3'd1;
        end else begin
          w_cand_n  = w_verdict;
          w_agree_n = 3'd1;
        end
        if (w_agree_n == 3'(CONFIRM)) begin
          w_state_n = ST_LOCKED;
          w_type_n  = w_cand_n;
          w_chg_n   = (w_cand_n != r_wave_type);
        end
      end
    end
  end

  logic       r_last_dn1;
  logic       r_seen;
  logic [7:0] r_pcnt;
  logic [7:0] r_period;
  logic       r_pvalid;
  logic       w_event;

  assign w_event = w_dvalid && ((w_cls == DC_JDN) || ((w_cls == DC_UP1) && r_last_dn1));

  // r_pcnt holds deltas since the last event, excluding the current one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_dn1 <= 1'b0;
      r_seen     <= 1'b0;
      r_pcnt     <= 8'd0;
      r_period   <= 8'd0;
      r_pvalid   <= 1'b0;
    end else if (w_dvalid) begin
      if (w_cls != DC_ZERO) r_last_dn1 <= (w_cls == DC_DN1);
      if (w_event) begin
        r_pcnt <= 8'd0;
        r_seen <= 1'b1;
        if (r_seen) begin
          r_period <= (r_pcnt == 8'hFF) ? 8'hFF : r_pcnt + 8'd1;
          r_pvalid <= 1'b1;
        end
      end else if (r_pcnt != 8'hFF) begin
        r_pcnt <= r_pcnt + 8'd1;
      end else if (r_seen) begin
        r_period <= 8'hFF;
      end
    end
  end

  assign wave_type    = r_wave_type;
  assign locked       = (r_state == ST_LOCKED);
  assign type_chg     = r_type_chg;
  assign period       = r_period;
  assign period_valid = r_pvalid;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/wave_detect.md
# wave_detect

Waveform classifier for the 5-bit sample stream produced by the team's signal generator; it is the receive side of that generator. It samples `wave` every clock, classifies each sample-to-sample step, accumulates step statistics over a fixed window, and reports which waveform is present: square, sawtooth, triangle, or unknown. After a configurable number of agreeing windows it locks, and it also reports the waveform period in samples. It sits downstream of the generator in self-checking benches and in loopback designs.

## Interface
- `WIN`, 64: window length in deltas (legal range 8..255).
- `CONFIRM`, 2: consecutive agreeing windows required to lock (legal range 1..7).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `wave`  in  5  unsigned sample, valid every cycle.
- `wave_type`  out  2  00 square, 01 sawtooth, 10 triangle, 11 unknown.
- `locked`  out  1  `wave_type` is confirmed and current.
- `type_chg`  out  1  one-cycle pulse when `wave_type` takes a new confirmed value.
- `period`  out  8  samples between consecutive period events; saturates at 255.
- `period_valid`  out  1  `period` holds a measured value.

## Operation
- Priming: the first sample after reset is stored as `prev` and produces no delta. Every later cycle produces d = wave − prev (6-bit signed), and `prev` is then updated.
- Delta class:
  - ZERO: d = 0.
  - UP1: d = +1.
  - DN1: d = −1.
  - JUP: d ≥ +2.
  - JDN: d ≤ −2.
- Window: five counters (8-bit, saturating) count classes over `WIN` deltas. At the window end the window is judged, the counters clear, and the next window starts on the following delta with no gap.
- Judgement rules:
  - Triangle: UP1>0, DN1>0, JUP=0, JDN=0.
  - Sawtooth: UP1>0, JDN>0, DN1=0, JUP=0.
  - Square: JUP>0, JDN>0, UP1=0, DN1=0.
  - Otherwise the window is unknown (11). This includes an all-ZERO window.
- Lock FSM, states UNLOCKED and LOCKED, with `cand` (2b) and `agree` (3b):
  - UNLOCKED, verdict ≠ 11: if verdict = `cand`, `agree`++; otherwise `cand` = verdict and `agree` = 1. When `agree` = CONFIRM, go to LOCKED and set `wave_type` = `cand`. If the new value differs from the old `wave_type`, pulse `type_chg`.
  - UNLOCKED, verdict = 11: `agree` = 0.
  - LOCKED, verdict = `wave_type`: stay in LOCKED.
  - LOCKED, any other verdict: go to UNLOCKED and deassert `locked`. `wave_type` holds its old value. `cand`/`agree` restart from this verdict, using the same rules as UNLOCKED.
  - `locked` = (state == LOCKED).
- Period events:
  - Any JDN is an event.
  - A valley is also an event: an UP1 whose last non-ZERO delta was DN1.
  - A free-running sample counter restarts at each event. At the second and later events, `period` = count since the previous event, and `period_valid` is set.
  - If the counter exceeds 255 without an event, `period` = 255 and `period_valid` stays set.

## Timing
- Reset values: `wave_type`=11, `locked`=0, `type_chg`=0, `period`=0, `period_valid`=0, state UNLOCKED, `cand`=11, `agree`=0, counters=0, prime pending.
- Reset asserted mid-operation returns every register to its reset value on that edge.
- With the first post-reset sample at cycle 0, the first delta is at cycle 1 and window k ends at the delta of cycle k·WIN.
- The verdict is registered on that same edge. `wave_type`, `locked` and `type_chg` update on the next edge (verdict latency 1).
- Earliest lock is at cycle CONFIRM·WIN + 1.
- `period` updates on the edge following the event delta.
- When a window end coincides with a period event, both take effect; they are independent.

## Structure
- Package `wave_pkg` holds:
  - type codes (`WT_SQUARE`, `WT_SAW`, `WT_TRI`, `WT_UNK`);
  - the delta-class enum;
  - the FSM state enum.
- Sub-module `wave_win_stats` holds the delta classifier, the window counter and the class counters, and outputs the verdict plus a window-end strobe.
- The top level holds the lock FSM and the period measurement.

## Test plan
All scenarios use WIN=64, CONFIRM=2.
- Triangle 0,1,…,20,19,…,1,0 repeating → `locked`=1 at cycle 129, `wave_type`=10, one `type_chg` pulse, `period`=40.
- Sawtooth 0..20 then wrap to 0 → `wave_type`=01, `locked`=1, `period`=21.
- Square (10 samples of 0, then 10 samples of 20) → `wave_type`=00, `period`=20.
- Locked sawtooth switched to triangle → the mixed window drops `locked` with `wave_type` still 01; after two clean triangle windows, `wave_type`=10, `locked`=1, and `type_chg` pulses once.
- Constant `wave`=7 → `wave_type`=11, `locked`=0, `period_valid`=0 throughout.
- `rst_n` low for one cycle while locked on triangle → all outputs at reset values next cycle; relock occurs 129 cycles after the first post-reset sample.
